stm_focus_sequencer: RTL and testbench
======================================

// Module: stm_focus_sequencer
// PURPOSE
//  Controller for the focus-STM datapath (the stm_focus-style calculator that
//  takes START/IDX and returns DEPTH intensity/phase beats on DOUT_VALID).
//  On each UPDATE tick it selects the focus index, pulses STM_START and holds
//  STM_IDX stable for the whole calculation.
//  Index stepping is frequency-divided, with loop/repetition control, double-buffered
//  config, overrun detection and a completion watchdog.
// PARAMETERS
//  DEPTH      249   beats per calculation (one per transducer)
//  IDX_WIDTH  13    focus index width
//  TIMEOUT    512   max cycles from STM_START to last beat before FAULT
// PORTS
//  CLK            in   1          system clock
//  RST            in   1          asynchronous, active-high reset
//  UPDATE         in   1          1-cycle tick: compute one new frame
//  CFG_VALID      in   1          1-cycle strobe: capture CFG_* into pending regs
//  CFG_CYCLE      in   IDX_WIDTH  last focus index (loop length - 1)
//  CFG_FREQ_DIV   in   16         UPDATE ticks per index step; 0 treated as 1
//  CFG_REP        in   16         loops to play; 0 = infinite
//  CLR_FLAGS      in   1          clears OVERRUN and FAULT
//  STM_START      out  1          1-cycle start pulse to datapath
//  STM_IDX        out  IDX_WIDTH  focus index to datapath, held while BUSY
//  STM_DOUT_VALID in   1          datapath output beat strobe
//  BUSY           out  1          calculation in flight
//  FINISHED       out  1          level: all CFG_REP loops played
//  OVERRUN        out  1          sticky: UPDATE arrived while BUSY
//  FAULT          out  1          sticky: watchdog expired
// BEHAVIOUR
//  Reset: all outputs 0.
//   Active config: cycle=0, freq_div=1, rep=0.
//   Counters idx/div_cnt/rep_cnt/beat_cnt/wd_cnt = 0; pending=0; state IDLE.
//  States: IDLE -> ISSUE -> RUN -> IDLE.
//  CFG_VALID in any state: latch pending regs and set pending flag.
//   Pending config is applied only in IDLE, on the cycle before an UPDATE is
//   accepted, or on the first IDLE cycle if no UPDATE is present.
//   Applying it zeroes idx/div_cnt/rep_cnt and clears FINISHED.
//  IDLE + UPDATE: STM_IDX<=idx, then go to ISSUE.
//   If UPDATE and a pending config coincide, the new config is applied first,
//   so the frame uses idx=0.
//  ISSUE (1 cycle):
//   - STM_START=1, BUSY=1, beat_cnt=0, wd_cnt=0.
//   - Advance unless FINISHED: div_cnt++.
//   - When div_cnt reaches freq_div-1: div_cnt=0; idx = (idx==cycle) ? 0 : idx+1.
//   - On wrap: rep_cnt++; if rep!=0 and rep_cnt+1==rep, set FINISHED and hold
//     idx at cycle (later frames repeat the last focus).
//   - Go to RUN.
//  RUN: each STM_DOUT_VALID beat increments beat_cnt.
//   Beat DEPTH-th -> IDLE, with BUSY=0 on the next cycle.
//   wd_cnt counts every RUN cycle.
//   wd_cnt==TIMEOUT-1 without completion -> FAULT=1, go to IDLE.
//  UPDATE while not IDLE (ISSUE/RUN): tick dropped and OVERRUN=1.
//   idx/div_cnt are not advanced.
//  Latency: UPDATE at cycle t -> STM_START at t+1.
//   STM_IDX is valid from t+1 and unchanged until BUSY falls.
//  Sticky flags: CLR_FLAGS clears both. Set wins if CLR_FLAGS and a set
//   condition coincide.
//  Beats outside RUN are ignored.
//  Widths: idx compare is unsigned IDX_WIDTH; counters wrap-free by construction
//   (div_cnt < freq_div, rep_cnt < rep).
//  Reset mid-RUN: abort immediately; BUSY=0, STM_START=0, no further START.
//   The datapath self-terminates.
// TESTING
//  1 cycle=3, div=1, rep=0; 8 UPDATEs with DEPTH beats each
//    -> STM_IDX 0,1,2,3,0,1,2,3; one START per UPDATE at t+1.
//  2 div=3, cycle=1 -> IDX 0,0,0,1,1,1,0; div=0 behaves as div=1.
//  3 cycle=2, rep=2, 8 UPDATEs -> IDX 0,1,2,0,1,2,2,2.
//    FINISHED rises in the ISSUE cycle of the 6th frame.
//  4 UPDATE 10 cycles after START (BUSY) -> OVERRUN=1, no START, next IDX unchanged.
//    CLR_FLAGS -> OVERRUN=0; CLR_FLAGS coincident with a new overrun -> stays 1.
//  5 Beats stop at 100 -> FAULT after TIMEOUT cycles in RUN, BUSY=0.
//    Next UPDATE issues normally.
//  6 CFG_VALID (cycle=5) mid-RUN at idx=2 -> applied after completion; next IDX=0.
//    RST during RUN -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/stm_focus_sequencer.sv
// Focus-STM sequencer: on each accepted UPDATE tick it latches the current
// focus index onto stm_idx_o, pulses stm_start_o and waits for DEPTH output
// beats from the datapath. Index stepping is divided by freq_div and limited
// to rep loops; config is double-buffered and only swapped in while idle.
module stm_focus_sequencer #(
  parameter int DEPTH     = 249,
  parameter int IDX_WIDTH = 13,
  parameter int TIMEOUT   = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 update_i,
  input  logic                 cfg_valid_i,
  input  logic [IDX_WIDTH-1:0] cfg_cycle_i,
  input  logic [15:0]          cfg_freq_div_i,
  input  logic [15:0]          cfg_rep_i,
  input  logic                 clr_flags_i,
  output logic                 stm_start_o,
  output logic [IDX_WIDTH-1:0] stm_idx_o,
  input  logic                 stm_dout_valid_i,
  output logic                 busy_o,
  output logic                 finished_o,
  output logic                 overrun_o,
  output logic                 fault_o
);

  localparam int BW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [BW-1:0]        BEAT_LAST = BW'(DEPTH - 1);
  localparam logic [WW-1:0]        WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN} state_t;

  state_t                 state_q;
  // active and pending (shadow) config; freq_div is stored already clamped to >=1
  logic [IDX_WIDTH-1:0]   cycle_q, pcycle_q;
  logic [15:0]            fdiv_q, pfdiv_q;
  logic [15:0]            rep_q, prep_q;
  logic                   pend_q;
  // sequencing counters
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [15:0]            div_q, div_d;
  logic [15:0]            repcnt_q, repcnt_d;
  logic                   fin_q, fin_d;
  logic [BW-1:0]          beat_q;
  logic [WW-1:0]          wd_q;
  // registered outputs
  logic [IDX_WIDTH-1:0]   stm_idx_q;
  logic                   start_q, busy_q, ovr_q, flt_q;
  logic                   apply;

  // Shadow config swaps in on any idle cycle where it is waiting.
  assign apply = (state_q == S_IDLE) && pend_q;

  // Index advance taken in ISSUE; frozen once all loops have been played.
  always_comb begin
    idx_d    = idx_q;
    div_d    = div_q;
    repcnt_d = repcnt_q;
    fin_d    = fin_q;
    if (!fin_q) begin
      if (div_q == fdiv_q - 16'd1) begin
        div_d = '0;
        if (idx_q == cycle_q) begin
          repcnt_d = repcnt_q + 16'd1;
          // last loop done: keep idx parked on the final focus
          if (rep_q != 16'd0 && (repcnt_q + 16'd1) == rep_q) fin_d = 1'b1;
          else                                                idx_d = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end
  end

  // Control FSM, config buffering, watchdog and sticky flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      fdiv_q    <= 16'd1;
      rep_q     <= '0;
      pcycle_q  <= '0;
      pfdiv_q   <= 16'd1;
      prep_q    <= '0;
      pend_q    <= 1'b0;
      idx_q     <= '0;
      div_q     <= '0;
      repcnt_q  <= '0;
      fin_q     <= 1'b0;
      beat_q    <= '0;
      wd_q      <= '0;
      stm_idx_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      flt_q     <= 1'b0;
    end else begin
      // clear first so a coincident set below takes priority
      if (clr_flags_i) begin
        ovr_q <= 1'b0;
        flt_q <= 1'b0;
      end
      if (cfg_valid_i) begin
        pend_q   <= 1'b1;
        pcycle_q <= cfg_cycle_i;
        pfdiv_q  <= (cfg_freq_div_i == 16'd0) ? 16'd1 : cfg_freq_div_i;
        prep_q   <= cfg_rep_i;
      end else if (apply) begin
        pend_q   <= 1'b0;
      end
      if (apply) begin
        cycle_q  <= pcycle_q;
        fdiv_q   <= pfdiv_q;
        rep_q    <= prep_q;
        idx_q    <= '0;
        div_q    <= '0;
        repcnt_q <= '0;
        fin_q    <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (update_i) begin
            stm_idx_q <= apply ? '0 : idx_q;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q  <= 1'b0;
          beat_q   <= '0;
          wd_q     <= '0;
          idx_q    <= idx_d;
          div_q    <= div_d;
          repcnt_q <= repcnt_d;
          fin_q    <= fin_d;
          if (update_i) ovr_q <= 1'b1;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (update_i) ovr_q <= 1'b1;
          if (stm_dout_valid_i && beat_q == BEAT_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (wd_q == WD_LAST) begin
            flt_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (stm_dout_valid_i) beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stm_start_o = start_q;
  assign stm_idx_o   = stm_idx_q;
  assign busy_o      = busy_q;
  assign finished_o  = fin_q;
  assign overrun_o   = ovr_q;
  assign fault_o     = flt_q;

endmodule

// File: tb/tb_stm_focus_sequencer.sv
// Bench for stm_focus_sequencer: frames are driven with randomised beat gaps
// and the expected index/finished state comes from a frame-count model.
module tb_stm_focus_sequencer;
  localparam int DEPTH = 249, IW = 13, TIMEOUT = 512;

  logic clk = 1'b0;
  logic rst, update, cfg_valid, clr_flags, dout_valid;
  logic [IW-1:0] cfg_cycle;
  logic [15:0] cfg_div, cfg_rep;
  logic stm_start, busy, finished, overrun, fault;
  logic [IW-1:0] stm_idx;

  always #5 clk = ~clk;

  stm_focus_sequencer #(.DEPTH(DEPTH), .IDX_WIDTH(IW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .update_i(update), .cfg_valid_i(cfg_valid),
    .cfg_cycle_i(cfg_cycle), .cfg_freq_div_i(cfg_div), .cfg_rep_i(cfg_rep),
    .clr_flags_i(clr_flags), .stm_start_o(stm_start), .stm_idx_o(stm_idx),
    .stm_dout_valid_i(dout_valid), .busy_o(busy), .finished_o(finished),
    .overrun_o(overrun), .fault_o(fault));

  int n_cmp = 0, n_err = 0;

  // Reference model: frames accepted since the last config load (m_k).
  // Frame k plays step k/fd; steps walk 0..cycle repeatedly and, with a finite
  // rep, park on 'cycle' once rep*(cycle+1) steps have been taken.
  int m_cycle = 0, m_fd = 1, m_rep = 0, m_k = 0;
  int nxt_cycle, nxt_div, nxt_rep;

  function automatic int exp_idx();
    int s = m_k / m_fd;
    int len = m_cycle + 1;
    if (m_rep != 0 && s >= m_rep * len) return m_cycle;
    return s % len;
  endfunction

  function automatic bit exp_fin();
    return (m_rep != 0) && ((m_k / m_fd) >= m_rep * (m_cycle + 1));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_load(input int c, input int d, input int r);
    m_cycle = c; m_fd = (d == 0) ? 1 : d; m_rep = r; m_k = 0;
  endtask

  // Strobe a config while idle; the following frame coincides with its apply.
  task automatic set_cfg(input int c, input int d, input int r);
    cfg_valid = 1'b1; cfg_cycle = IW'(c); cfg_div = 16'(d); cfg_rep = 16'(r);
    tick();
    cfg_valid = 1'b0;
    model_load(c, d, r);
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
  endtask

  // One frame: UPDATE, then nbeats datapath beats with random gaps. act at beat
  // act_at: 1 = stray UPDATE, 2 = new config (nxt_*), 3 = UPDATE + CLR_FLAGS.
  // nbeats < DEPTH exercises the watchdog.
  task automatic frame(input int nbeats, input int act_at, input int act);
    logic [IW-1:0] e_idx;
    int nrun;
    bit bad;
    e_idx = IW'(exp_idx());
    bad = 1'b0;
    nrun = 0;
    update = 1'b1;
    dout_valid = 1'($urandom_range(0, 1));
    tick();
    update = 1'b0;
    n_cmp++;
    if (stm_start !== 1'b1 || busy !== 1'b1 || stm_idx !== e_idx) begin
      n_err++;
      $display("FAIL issue: start=%b busy=%b idx=%0d, want 1 1 %0d", stm_start, busy, stm_idx, e_idx);
    end
    m_k++;
    dout_valid = 1'($urandom_range(0, 1));  // ISSUE cycle: must be ignored
    tick();
    if (stm_start !== 1'b0 || busy !== 1'b1 || stm_idx !== e_idx) bad = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        dout_valid = 1'b0;
        tick(); nrun++;
        if (stm_start !== 1'b0 || busy !== 1'b1 || stm_idx !== e_idx) bad = 1'b1;
      end
      if (b == act_at) begin
        case (act)
          1: update = 1'b1;
          2: begin
            cfg_valid = 1'b1; cfg_cycle = IW'(nxt_cycle);
            cfg_div = 16'(nxt_div); cfg_rep = 16'(nxt_rep);
          end
          3: begin update = 1'b1; clr_flags = 1'b1; end
          default: ;
        endcase
      end
      dout_valid = 1'b1;
      tick(); nrun++;
      update = 1'b0; cfg_valid = 1'b0; clr_flags = 1'b0;
      if (b == act_at && (act == 1 || act == 3)) begin
        n_cmp++;
        if (overrun !== 1'b1) begin
          n_err++;
          $display("FAIL overrun_set act=%0d: overrun=%b, want 1", act, overrun);
        end
      end
      if (b < DEPTH - 1 && (stm_start !== 1'b0 || busy !== 1'b1 || stm_idx !== e_idx)) bad = 1'b1;
    end
    dout_valid = 1'b0;
    if (nbeats >= DEPTH) begin
      n_cmp++;
      if (busy !== 1'b0 || bad) begin
        n_err++;
        $display("FAIL frame_done idx=%0d: busy=%b hold_err=%b, want busy 0 hold_err 0", e_idx, busy, bad);
      end
    end else begin
      while (nrun < TIMEOUT - 1) begin
        tick(); nrun++;
        if (busy !== 1'b1 || stm_start !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (fault !== 1'b0 || bad) begin
        n_err++;
        $display("FAIL wd_early: fault=%b hold_err=%b, want 0 0", fault, bad);
      end
      tick();
      n_cmp++;
      if (fault !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL wd_fire: fault=%b busy=%b, want 1 0", fault, busy);
      end
    end
    n_cmp++;
    if (finished !== exp_fin()) begin
      n_err++;
      $display("FAIL finished k=%0d: finished=%b, want %b", m_k, finished, exp_fin());
    end
    if (act == 2) model_load(nxt_cycle, nxt_div, nxt_rep);
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({stm_start, busy, finished, overrun, fault} !== 5'b0 || stm_idx !== '0) begin
      n_err++;
      $display("FAIL %s: start=%b busy=%b fin=%b ovr=%b flt=%b idx=%0d, want all 0",
               tag, stm_start, busy, finished, overrun, fault, stm_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; update = 0; cfg_valid = 0; clr_flags = 0; dout_valid = 0;
    cfg_cycle = '0; cfg_div = '0; cfg_rep = '0;
    tick(); tick();
    check_all_zero("reset_hold");
    rst = 1'b0;
    tick();
    check_all_zero("reset_release");
    model_load(0, 1, 0);
    frame(DEPTH, -1, 0);  // default config: cycle 0 -> idx 0
  endtask

  task automatic test_basic_loop();
    set_cfg(3, 1, 0);
    for (int i = 0; i < 8; i++) frame(DEPTH, -1, 0);
  endtask

  task automatic test_freq_div();
    set_cfg(1, 3, 0);
    for (int i = 0; i < 7; i++) frame(DEPTH, -1, 0);
    set_cfg(1, 0, 0);
    tick(); tick();  // apply on an idle cycle without UPDATE
    for (int i = 0; i < 4; i++) frame(DEPTH, -1, 0);
  endtask

  task automatic test_repetition();
    set_cfg(2, 1, 2);
    for (int i = 0; i < 8; i++) frame(DEPTH, -1, 0);
  endtask

  task automatic test_overrun();
    set_cfg(3, 1, 0);
    frame(DEPTH, -1, 0);
    frame(DEPTH, 10, 1);
    frame(DEPTH, -1, 0);  // dropped tick must not have advanced idx
    clear_flags();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: overrun=%b, want 0", overrun);
    end
    frame(DEPTH, 7, 1);
    frame(DEPTH, 12, 3);  // clear + new overrun together: set wins
    clear_flags();
  endtask

  task automatic test_watchdog();
    frame(100, -1, 0);
    frame(DEPTH, -1, 0);
    n_cmp++;
    if (fault !== 1'b1) begin
      n_err++;
      $display("FAIL fault_sticky: fault=%b, want 1", fault);
    end
    clear_flags();
    n_cmp++;
    if (fault !== 1'b0) begin
      n_err++;
      $display("FAIL fault_clear: fault=%b, want 0", fault);
    end
  endtask

  task automatic test_cfg_midrun_and_reset();
    set_cfg(3, 1, 0);
    frame(DEPTH, -1, 0);
    frame(DEPTH, -1, 0);
    nxt_cycle = 5; nxt_div = 1; nxt_rep = 0;
    frame(DEPTH, 40, 2);  // idx 2 frame, config lands mid-run
    frame(DEPTH, -1, 0);  // expects idx 0
    frame(DEPTH, -1, 0);
    // reset in the middle of a run
    update = 1'b1; tick(); update = 1'b0;
    tick();
    for (int b = 0; b < 20; b++) begin dout_valid = 1'b1; tick(); end
    dout_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("reset_midrun");
    tick();
    rst = 1'b0;
    model_load(0, 1, 0);
    begin
      bit bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
        dout_valid = 1'($urandom_range(0, 1));
        tick();
        if (stm_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      dout_valid = 1'b0;
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL post_reset_quiet: start/busy seen high, want 0");
      end
    end
    frame(DEPTH, -1, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 2));
      for (int i = 0; i < 8; i++) begin
        frame(DEPTH, -1, 0);
        repeat ($urandom_range(0, 3)) tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_loop();
    test_freq_div();
    test_repetition();
    test_overrun();
    test_watchdog();
    test_cfg_midrun_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end

endmodule
